// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel and
// the instruction stream handed to decode.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  // Fetch unit side: drives requests and the decode stream.
  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  // Memory/decode side: answers requests and consumes instructions.
  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding instruction
// memory reads, a 2-entry {pc, word} buffer towards decode, and redirect /
// wrong-path flushing driven by the branch-resolution signals from execute.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               br_valid,
  input  logic               PCAsrc,
  input  logic               PCBsrc,
  input  logic [XLEN-1:0]    br_pc,
  input  logic [XLEN-1:0]    br_rs1,
  input  logic [XLEN-1:0]    br_imm,
  instr_fetch_unit_if.master bus,
  output logic               fault,
  output logic [XLEN-1:0]    fault_pc
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    HALT
  } state_t;

  state_t          state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            head_vld_q, head_vld_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] head_data_q, head_data_d;
  logic            tail_vld_q, tail_vld_d;
  logic [XLEN-1:0] tail_pc_q, tail_pc_d;
  logic [XLEN-1:0] tail_data_q, tail_data_d;

  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic            redirect;
  logic [XLEN-1:0] target_base;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic            handshake;
  logic            pop;
  logic            push;

  // Once halted on a fault, further redirects are ignored until reset.
  assign redirect    = br_valid & PCAsrc & (state_q != HALT);
  assign target_base = PCBsrc ? br_rs1 : br_pc;
  assign target_sum  = target_base + br_imm;
  assign target      = PCBsrc ? {target_sum[XLEN-1:1], 1'b0} : target_sum;

  // req_valid_q can only be high in IDLE, so this is the accepted request.
  assign handshake   = req_valid_q & bus.imem_req_ready;
  assign pop         = head_vld_q & bus.inst_ready;

  // Next-state, PC, buffer and fault computation; redirect outranks the
  // memory response, which outranks a decode pop.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    head_vld_d  = head_vld_q;
    head_pc_d   = head_pc_q;
    head_data_d = head_data_q;
    tail_vld_d  = tail_vld_q;
    tail_pc_d   = tail_pc_q;
    tail_data_d = tail_data_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    push        = 1'b0;

    if (redirect) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
      if (target[1]) begin
        state_d    = HALT;
        fault_d    = 1'b1;
        fault_pc_d = target;
      end else begin
        pc_d = target;
        case (state_q)
          IDLE:       state_d = handshake ? DROP : IDLE;
          WAIT, DROP: state_d = bus.imem_rsp_valid ? IDLE : DROP;
          default:    state_d = state_q;
        endcase
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            state_d  = WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_d = IDLE;
            push    = 1'b1;
          end
        end
        DROP: begin
          if (bus.imem_rsp_valid) begin
            state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase

      if (push && pop) begin
        if (tail_vld_q) begin
          head_pc_d   = tail_pc_q;
          head_data_d = tail_data_q;
          tail_pc_d   = req_pc_q;
          tail_data_d = bus.imem_rsp_data;
        end else begin
          head_pc_d   = req_pc_q;
          head_data_d = bus.imem_rsp_data;
        end
      end else if (pop) begin
        head_vld_d  = tail_vld_q;
        head_pc_d   = tail_pc_q;
        head_data_d = tail_data_q;
        tail_vld_d  = 1'b0;
      end else if (push) begin
        if (!head_vld_q) begin
          head_vld_d  = 1'b1;
          head_pc_d   = req_pc_q;
          head_data_d = bus.imem_rsp_data;
        end else begin
          tail_vld_d  = 1'b1;
          tail_pc_d   = req_pc_q;
          tail_data_d = bus.imem_rsp_data;
        end
      end
    end

    // With nothing outstanding in IDLE, a free tail slot means room.
    req_valid_d = (state_d == IDLE) && !tail_vld_d;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, request, buffer entries and fault capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      head_vld_q  <= 1'b0;
      head_pc_q   <= '0;
      head_data_q <= '0;
      tail_vld_q  <= 1'b0;
      tail_pc_q   <= '0;
      tail_data_q <= '0;
      fault_q     <= 1'b0;
      fault_pc_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      head_vld_q  <= head_vld_d;
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
      tail_vld_q  <= tail_vld_d;
      tail_pc_q   <= tail_pc_d;
      tail_data_q <= tail_data_d;
      fault_q     <= fault_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = head_vld_q;
  assign bus.inst_pc        = head_pc_q;
  assign bus.inst_data      = head_data_q;
  assign fault              = fault_q;
  assign fault_pc           = fault_pc_q;

endmodule
